// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter that shares one byte-level I2C master among NUM_REQ requesters,
// with a power-up hold-off before the first grant and a watchdog on master completion.
//
// state     | meaning
// HOLDOFF   | power-up settling; requests are left pending, not served
// IDLE      | ready; grant the next pending requester in round-robin order
// ISSUE     | one-cycle m_start to the master, watchdog cleared
// WAIT_DONE | waiting for m_done or watchdog expiry
// COMPLETE  | one-cycle done pulse to the owner, response valid
module i2c_master_arbiter #(
    parameter int          NUM_REQ        = 4,
    parameter logic [27:0] STARTUP_CYCLES = 28'd100000000,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [7*NUM_REQ-1:0] req_addr,
    input  logic [NUM_REQ-1:0]   req_rw,
    input  logic [8*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   done,
    output logic [7:0]           rsp_rdata,
    output logic                 rsp_err,
    output logic                 rsp_timeout,
    output logic                 ready,
    output logic                 m_start,
    output logic [6:0]           m_addr,
    output logic                 m_rw,
    output logic [7:0]           m_wdata,
    input  logic                 m_done,
    input  logic                 m_ack_err,
    input  logic [7:0]           m_rdata
);
    localparam int            PW          = $clog2(NUM_REQ);
    localparam logic [PW-1:0] LAST_IDX    = PW'(NUM_REQ - 1);
    localparam logic [PW-1:0] IDX_ONE     = PW'(1);
    localparam logic [27:0]   HOLDOFF_TC  = STARTUP_CYCLES - 28'd1;
    localparam logic [23:0]   WATCHDOG_TC = TIMEOUT_CYCLES - 24'd1;

    typedef enum logic [2:0] {
        S_HOLDOFF   = 3'd0,
        S_IDLE      = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_COMPLETE  = 3'd4
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [27:0]   holdoff_cnt;
    logic [23:0]   wd_cnt;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] owner_idx;
    logic [PW-1:0] pick_idx;
    logic [PW-1:0] cand;
    logic          pick_valid;
    logic          holdoff_tc;
    logic          wd_tc;

    logic [6:0] slot_addr  [NUM_REQ];
    logic [7:0] slot_wdata [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
        assign slot_addr[i]  = req_addr[7*i +: 7];
        assign slot_wdata[i] = req_wdata[8*i +: 8];
    end

    assign holdoff_tc = (holdoff_cnt == HOLDOFF_TC);
    assign wd_tc      = (wd_cnt == WATCHDOG_TC);

    // Scan starts one past the last owner, so the last owner has lowest priority.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (cand == LAST_IDX) ? '0 : cand + IDX_ONE;
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_HOLDOFF;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_HOLDOFF:   if (holdoff_tc) state_nxt = S_IDLE;
            S_IDLE:      if (pick_valid) state_nxt = S_ISSUE;
            S_ISSUE:     state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: if (m_done || wd_tc) state_nxt = S_COMPLETE;
            S_COMPLETE:  state_nxt = S_IDLE;
            default:     state_nxt = S_HOLDOFF;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            holdoff_cnt <= '0;
            wd_cnt      <= '0;
            rr_ptr      <= LAST_IDX;
            owner_idx   <= '0;
            grant       <= '0;
            m_addr      <= '0;
            m_rw        <= 1'b0;
            m_wdata     <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                S_HOLDOFF: begin
                    if (!holdoff_tc) holdoff_cnt <= holdoff_cnt + 28'd1;
                end
                S_IDLE: begin
                    if (pick_valid) begin
                        owner_idx       <= pick_idx;
                        grant           <= '0;
                        grant[pick_idx] <= 1'b1;
                        m_addr          <= slot_addr[pick_idx];
                        m_rw            <= req_rw[pick_idx];
                        m_wdata         <= slot_wdata[pick_idx];
                    end
                end
                S_ISSUE: begin
                    wd_cnt <= '0;
                end
                S_WAIT_DONE: begin
                    // A real completion beats a watchdog expiry in the same cycle.
                    if (m_done) begin
                        rsp_rdata   <= m_rdata;
                        rsp_err     <= m_ack_err;
                        rsp_timeout <= 1'b0;
                    end else if (wd_tc) begin
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 24'd1;
                    end
                end
                S_COMPLETE: begin
                    rr_ptr      <= owner_idx;
                    grant       <= '0;
                    rsp_rdata   <= '0;
                    rsp_err     <= 1'b0;
                    rsp_timeout <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign ready   = (state != S_HOLDOFF);
    assign m_start = (state == S_ISSUE);
    assign done    = (state == S_COMPLETE) ? grant : '0;

endmodule
